ct_lsu_idfifo_param: RTL and testbench

CT_LSU_IDFIFO_PARAM -- requirements
Module: ct_lsu_idfifo_param

---
 rtl/ct_lsu_idfifo_param_pkg.sv | 19 +
 rtl/ct_lsu_idfifo_param_entry.sv | 25 ++
 rtl/ct_lsu_idfifo_param_gated_clk.sv | 27 ++
 rtl/ct_lsu_idfifo_param.sv | 146 ++++++++++++++
 tb/tb_ct_lsu_idfifo_param.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/ct_lsu_idfifo_param_pkg.sv
// Shared LSU constants for the ID FIFO: default geometry and a log2 helper.
package ct_lsu_idfifo_param_pkg;

    localparam int unsigned LSU_IDFIFO_DEPTH = 8;
    localparam int unsigned LSU_IDFIFO_ID_W  = 3;

    // Ceiling log2; callers pass powers of two, so this is the exact log2.
    function automatic int unsigned lsu_log2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ct_lsu_idfifo_param_entry.sv
// One FIFO slot: an ID_W-bit register written only when its write enable is set.
module ct_lsu_idfifo_entry_p #(
    parameter int unsigned ID_W = 3
) (
    input  logic            entry_clk,
    input  logic            cpurst_b,
    input  logic            entry_wen,
    input  logic [ID_W-1:0] entry_din,
    output logic [ID_W-1:0] entry_dout
);

    logic [ID_W-1:0] id_reg;

    // Slot storage; cleared only by reset, never by flush.
    always_ff @(posedge entry_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            id_reg <= '0;
        end else if (entry_wen) begin
            id_reg <= entry_din;
        end
    end

    assign entry_dout = id_reg;

endmodule

// File: rtl/ct_lsu_idfifo_param_gated_clk.sv
// Latch-based clock gate: enable is captured while the clock is low so the
// gated clock can never glitch; scan enable forces the clock through.
module gated_clk_cell (
    input  logic clk_in,
    input  logic global_en,
    input  logic module_en,
    input  logic local_en,
    input  logic external_en,
    input  logic pad_yy_icg_scan_en,
    output logic clk_out
);

    logic clk_en_bf_latch;
    logic clk_en_af_latch;

    assign clk_en_bf_latch = (global_en & (module_en | local_en)) | external_en;

    // Transparent-low enable latch.
    always_latch begin
        if (!clk_in) begin
            clk_en_af_latch <= clk_en_bf_latch;
        end
    end

    assign clk_out = clk_in & (clk_en_af_latch | pad_yy_icg_scan_en);

endmodule

// File: rtl/ct_lsu_idfifo_param.sv
// LSU ID FIFO: stores IDs in order and presents the head as a registered
// binary and one-hot value with no read latency beyond the push cycle.
module ct_lsu_idfifo_param
    import ct_lsu_idfifo_param_pkg::*;
#(
    parameter int unsigned DEPTH = LSU_IDFIFO_DEPTH,
    parameter int unsigned ID_W  = LSU_IDFIFO_ID_W,
    localparam int unsigned AW     = lsu_log2(DEPTH),
    localparam int unsigned PTR_W  = AW + 1,
    localparam int unsigned CNT_W  = PTR_W,
    localparam int unsigned ID_NUM = 1 << ID_W
) (
    input  logic              forever_cpuclk,
    input  logic              cpurst_b,
    input  logic              cp0_yy_clk_en,
    input  logic              cp0_lsu_icg_en,
    input  logic              pad_yy_icg_scan_en,
    input  logic              idfifo_create_vld,
    input  logic [ID_W-1:0]   idfifo_create_id,
    input  logic              idfifo_pop_vld,
    input  logic              idfifo_flush,
    output logic [ID_NUM-1:0] idfifo_pop_id_oh,
    output logic [ID_W-1:0]   idfifo_pop_id,
    output logic              idfifo_empty,
    output logic              idfifo_full,
    output logic [CNT_W-1:0]  idfifo_cnt,
    output logic              idfifo_err
);

    function automatic logic [ID_NUM-1:0] id_to_oh(input logic [ID_W-1:0] id);
        logic [ID_NUM-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

    logic [PTR_W-1:0]  create_ptr_reg, create_ptr_next;
    logic [PTR_W-1:0]  pop_ptr_reg, pop_ptr_next;
    logic [ID_W-1:0]   pop_id_reg, pop_id_next;
    logic [ID_NUM-1:0] pop_id_oh_reg, pop_id_oh_next;
    logic              err_reg, err_next;

    logic              empty, full;
    logic [CNT_W-1:0]  cnt;
    logic              pop_acc, create_acc, err_pending, local_en;
    logic              idfifo_clk;
    logic [AW-1:0]     head_next_idx;
    logic [DEPTH-1:0]  entry_wen;
    logic [ID_W-1:0]   entry_dout [DEPTH];

    assign empty = (create_ptr_reg == pop_ptr_reg);
    assign full  = (create_ptr_reg[AW-1:0] == pop_ptr_reg[AW-1:0]) &&
                   (create_ptr_reg[AW] != pop_ptr_reg[AW]);
    assign cnt   = create_ptr_reg - pop_ptr_reg;

    // A pop frees a slot in the same cycle, so a full FIFO can still take a create.
    assign pop_acc       = idfifo_pop_vld & ~empty;
    assign create_acc    = idfifo_create_vld & (~full | pop_acc);
    assign err_pending   = (idfifo_create_vld & ~create_acc) | (idfifo_pop_vld & empty);
    assign local_en      = idfifo_create_vld | idfifo_pop_vld | idfifo_flush | err_pending;
    assign head_next_idx = pop_ptr_reg[AW-1:0] + AW'(1);

    gated_clk_cell x_idfifo_gated_clk (
        .clk_in             (forever_cpuclk),
        .global_en          (cp0_yy_clk_en),
        .module_en          (cp0_lsu_icg_en),
        .local_en           (local_en),
        .external_en        (1'b0),
        .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
        .clk_out            (idfifo_clk)
    );

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign entry_wen[gi] = create_acc & ~idfifo_flush &
                                   (create_ptr_reg[AW-1:0] == AW'(gi));
            ct_lsu_idfifo_entry_p #(.ID_W(ID_W)) x_entry (
                .entry_clk  (idfifo_clk),
                .cpurst_b   (cpurst_b),
                .entry_wen  (entry_wen[gi]),
                .entry_din  (idfifo_create_id),
                .entry_dout (entry_dout[gi])
            );
        end
    endgenerate

    // Next pointers, head value and sticky error; flush overrides everything.
    always_comb begin
        create_ptr_next = create_ptr_reg;
        pop_ptr_next    = pop_ptr_reg;
        pop_id_next     = pop_id_reg;
        pop_id_oh_next  = pop_id_oh_reg;
        err_next        = err_reg | err_pending;
        if (idfifo_flush) begin
            create_ptr_next = '0;
            pop_ptr_next    = '0;
            pop_id_next     = '0;
            pop_id_oh_next  = '0;
            err_next        = 1'b0;
        end else begin
            if (create_acc) begin
                create_ptr_next = create_ptr_reg + PTR_W'(1);
            end
            if (pop_acc) begin
                pop_ptr_next = pop_ptr_reg + PTR_W'(1);
            end
            // New ID becomes the head directly when nothing older remains.
            if (create_acc && (empty || (cnt == CNT_W'(1) && pop_acc))) begin
                pop_id_next    = idfifo_create_id;
                pop_id_oh_next = id_to_oh(idfifo_create_id);
            end else if (pop_acc && cnt == CNT_W'(1)) begin
                pop_id_next    = '0;
                pop_id_oh_next = '0;
            end else if (pop_acc) begin
                pop_id_next    = entry_dout[head_next_idx];
                pop_id_oh_next = id_to_oh(entry_dout[head_next_idx]);
            end
        end
    end

    // Control state register on the gated clock.
    always_ff @(posedge idfifo_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            create_ptr_reg <= '0;
            pop_ptr_reg    <= '0;
            pop_id_reg     <= '0;
            pop_id_oh_reg  <= '0;
            err_reg        <= 1'b0;
        end else begin
            create_ptr_reg <= create_ptr_next;
            pop_ptr_reg    <= pop_ptr_next;
            pop_id_reg     <= pop_id_next;
            pop_id_oh_reg  <= pop_id_oh_next;
            err_reg        <= err_next;
        end
    end

    assign idfifo_pop_id_oh = pop_id_oh_reg;
    assign idfifo_pop_id    = pop_id_reg;
    assign idfifo_empty     = empty;
    assign idfifo_full      = full;
    assign idfifo_cnt       = cnt;
    assign idfifo_err       = err_reg;

endmodule

// File: tb/tb_ct_lsu_idfifo_param.sv
// Directed bench for the LSU ID FIFO (DEPTH=8, ID_W=3).
module tb_ct_lsu_idfifo_param;

    logic       clk;
    logic       rst_n;
    logic       cp0_yy_clk_en, cp0_lsu_icg_en, scan_en;
    logic       create_vld, pop_vld, flush;
    logic [2:0] create_id;
    logic [7:0] pop_id_oh;
    logic [2:0] pop_id;
    logic       empty, full, err;
    logic [3:0] cnt;

    int n_cmp = 0;
    int n_mis = 0;

    ct_lsu_idfifo_param dut (
        .forever_cpuclk     (clk),
        .cpurst_b           (rst_n),
        .cp0_yy_clk_en      (cp0_yy_clk_en),
        .cp0_lsu_icg_en     (cp0_lsu_icg_en),
        .pad_yy_icg_scan_en (scan_en),
        .idfifo_create_vld  (create_vld),
        .idfifo_create_id   (create_id),
        .idfifo_pop_vld     (pop_vld),
        .idfifo_flush       (flush),
        .idfifo_pop_id_oh   (pop_id_oh),
        .idfifo_pop_id      (pop_id),
        .idfifo_empty       (empty),
        .idfifo_full        (full),
        .idfifo_cnt         (cnt),
        .idfifo_err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic c, input logic [2:0] id, input logic p, input logic f);
        create_vld = c;
        create_id  = id;
        pop_vld    = p;
        flush      = f;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [7:0] oh, input logic [3:0] c,
                             input logic e, input logic fu, input logic er);
        chk({tag, ".oh"}, 32'(pop_id_oh), 32'(oh));
        chk({tag, ".cnt"}, 32'(cnt), 32'(c));
        chk({tag, ".empty"}, 32'(empty), 32'(e));
        chk({tag, ".full"}, 32'(full), 32'(fu));
        chk({tag, ".err"}, 32'(err), 32'(er));
        $display("step %s: oh=%02h id=%0d cnt=%0d empty=%0b full=%0b err=%0b",
                 tag, pop_id_oh, pop_id, cnt, empty, full, err);
    endtask

    initial begin
        logic [2:0] drain_exp [7];
        logic [2:0] q [$];
        logic [2:0] id_k;
        logic [7:0] exp_oh;
        logic       c_en, p_en, p_ok, c_ok;

        rst_n = 1'b0;
        cp0_yy_clk_en  = 1'b1;
        cp0_lsu_icg_en = 1'b0;
        scan_en        = 1'b0;
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        #1;
        chk_state("reset", 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("reset.id", 32'(pop_id), 32'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // Push 5,2,7 then pop three times.
        drive(1'b1, 3'd5, 1'b0, 1'b0); cyc();
        chk_state("push5", 8'h20, 4'd1, 1'b0, 1'b0, 1'b0);
        chk("push5.id", 32'(pop_id), 32'd5);
        drive(1'b1, 3'd2, 1'b0, 1'b0); cyc();
        drive(1'b1, 3'd7, 1'b0, 1'b0); cyc();
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        chk_state("push3", 8'h20, 4'd3, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 3'd0, 1'b1, 1'b0); cyc();
        chk_state("pop1", 8'h04, 4'd2, 1'b0, 1'b0, 1'b0);
        chk("pop1.id", 32'(pop_id), 32'd2);
        cyc();
        chk_state("pop2", 8'h80, 4'd1, 1'b0, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        chk_state("pop3", 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);

        // Create and pop on empty: pop ignored, underflow flagged.
        drive(1'b1, 3'd3, 1'b1, 1'b0); cyc();
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        chk_state("cp_empty", 8'h08, 4'd1, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 3'd0, 1'b0, 1'b1); cyc();
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        chk_state("flush1", 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);

        // cnt==1 with simultaneous create and pop: bypass.
        drive(1'b1, 3'd4, 1'b0, 1'b0); cyc();
        chk_state("push4", 8'h10, 4'd1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'd1, 1'b1, 1'b0); cyc();
        chk_state("cp_cnt1", 8'h02, 4'd1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 3'd0, 1'b1, 1'b0); cyc();
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        chk_state("pop_last", 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);

        // Fill to full with IDs 1..7,0; overflow; create+pop while full.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 3'(i), 1'b0, 1'b0); cyc();
        end
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        chk_state("full", 8'h02, 4'd8, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 3'd6, 1'b0, 1'b0); cyc();
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        chk_state("ovf", 8'h02, 4'd8, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 3'd6, 1'b1, 1'b0); cyc();
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        chk_state("full_cp", 8'h04, 4'd8, 1'b0, 1'b1, 1'b1);
        drain_exp = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd6};
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 3'd0, 1'b1, 1'b0); cyc();
            exp_oh = 8'd1 << drain_exp[i];
            chk_state($sformatf("drain%0d", i), exp_oh, 4'(7 - i), 1'b0, 1'b0, 1'b1);
        end
        drive(1'b0, 3'd0, 1'b1, 1'b0); cyc();
        drive(1'b0, 3'd0, 1'b0, 1'b1); cyc();
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        chk_state("drained", 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);

        // Stream 20 IDs: 3 pushes, 17 push+pop, 3 pops; pointers wrap.
        q = {};
        for (int k = 0; k < 23; k++) begin
            c_en = (k < 20);
            p_en = (k >= 3);
            id_k = 3'((k * 5 + 3) % 8);
            drive(c_en, id_k, p_en, 1'b0); cyc();
            p_ok = p_en && (q.size() > 0);
            c_ok = c_en && ((q.size() < 8) || p_ok);
            if (p_ok) void'(q.pop_front());
            if (c_ok) q.push_back(id_k);
            exp_oh = 8'h00;
            if (q.size() > 0) exp_oh = 8'd1 << q[0];
            chk_state($sformatf("stream%0d", k), exp_oh, 4'(q.size()),
                      q.size() == 0, q.size() == 8, 1'b0);
        end
        drive(1'b0, 3'd0, 1'b0, 1'b0);

        // Flush at cnt=5 with a same-cycle create, after setting err.
        drive(1'b0, 3'd0, 1'b1, 1'b0); cyc();
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        chk("unf.err", 32'(err), 32'd1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'((2 * i + 1) % 8), 1'b0, 1'b0); cyc();
        end
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        chk_state("cnt5", 8'h02, 4'd5, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 3'd2, 1'b0, 1'b1); cyc();
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        chk_state("flush_c", 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-stream.
        drive(1'b1, 3'd4, 1'b0, 1'b0); cyc();
        drive(1'b1, 3'd6, 1'b0, 1'b0); cyc();
        drive(1'b1, 3'd1, 1'b1, 1'b0); cyc();
        drive(1'b1, 3'd5, 1'b0, 1'b0);
        chk_state("pre_rst", 8'h40, 4'd2, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("async_rst", 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("async_rst.id", 32'(pop_id), 32'd0);
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        cyc();
        rst_n = 1'b1;
        cyc();
        drive(1'b1, 3'd6, 1'b0, 1'b0); cyc();
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        chk_state("post_rst", 8'h40, 4'd1, 1'b0, 1'b0, 1'b0);
        chk("post_rst.id", 32'(pop_id), 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
